// File: rtl/cnt_updn_ld_if.sv
// Bus bundle for the up/down/load counter.
// master drives the load value and the count requests; slave is the counter,
// which returns the count and its status flags.
interface cnt_updn_ld_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] in;
  logic             latch;
  logic             dec;
  logic             inc;
  logic [WIDTH-1:0] count;
  logic             zero;
  logic             full;
  logic             tc;

  modport master (
    output in, latch, dec, inc,
    input  count, zero, full, tc
  );

  modport slave (
    input  in, latch, dec, inc,
    output count, zero, full, tc
  );
endinterface

// File: rtl/cnt_updn_ld.sv
// Up/down counter with parallel load and a one-cycle terminal-count pulse.
// Per cycle the priority is: latch, then exactly one of inc/dec, else hold.
// SATURATE=1 clamps at 0 and at max; SATURATE=0 wraps modulo 2^WIDTH.
// Optional feature macro CNT_RELOAD_EN: adds a reload register, written by
// every latch, that is loaded into the count when a decrement hits 0.
// The bus interface instance must be built with the same WIDTH as this module.
module cnt_updn_ld #(
  parameter int WIDTH    = 4,
  parameter int SATURATE = 1
) (
  input  logic          clk,
  input  logic          rst,
  cnt_updn_ld_if.slave  bus
);

  localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             do_inc, do_dec;

`ifdef CNT_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  // inc and dec together cancel out, so only one-sided requests count
  assign do_inc = bus.inc & ~bus.dec;
  assign do_dec = bus.dec & ~bus.inc;

  // Next-state: load beats count; tc only pulses on 1->0 or on a max->0 wrap
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
`ifdef CNT_RELOAD_EN
    reload_d = reload_q;
`endif
    if (bus.latch) begin
      count_d = bus.in;
`ifdef CNT_RELOAD_EN
      reload_d = bus.in;
`endif
    end else if (do_inc) begin
      if (count_q != CNT_MAX) begin
        count_d = count_q + CNT_ONE;
      end else if (SATURATE == 0) begin
        count_d = CNT_ZERO;
        tc_d    = 1'b1;
      end
    end else if (do_dec) begin
      if (count_q != CNT_ZERO) begin
        count_d = count_q - CNT_ONE;
        tc_d    = (count_q == CNT_ONE);
      end else begin
`ifdef CNT_RELOAD_EN
        // Auto-reload takes precedence over both saturate and wrap at zero
        count_d = reload_q;
        tc_d    = 1'b1;
`else
        if (SATURATE == 0) begin
          count_d = CNT_MAX;
        end
`endif
      end
    end
  end

  // State registers, cleared immediately by the asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= CNT_ZERO;
      tc_q    <= 1'b0;
`ifdef CNT_RELOAD_EN
      reload_q <= CNT_ZERO;
`endif
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
`ifdef CNT_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  // Flags decode straight from the count register, so they track it with no lag
  assign bus.count = count_q;
  assign bus.tc    = tc_q;
  assign bus.zero  = (count_q == CNT_ZERO);
  assign bus.full  = (count_q == CNT_MAX);

endmodule

// File: tb/tb_cnt_updn_ld.sv
// Bench for cnt_updn_ld: one saturating and one wrapping instance side by side,
// a vector table, hand-written reset/reload sequences and random stimulus
// against a plain-arithmetic reference model.
module tb_cnt_updn_ld;

  localparam int W    = 4;
  localparam int MAXV = (1 << W) - 1;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   txn    = 0;

  cnt_updn_ld_if #(.WIDTH(W)) if_s ();
  cnt_updn_ld_if #(.WIDTH(W)) if_w ();

  cnt_updn_ld #(.WIDTH(W), .SATURATE(1)) dut_s (.clk(clk), .rst(rst), .bus(if_s));
  cnt_updn_ld #(.WIDTH(W), .SATURATE(0)) dut_w (.clk(clk), .rst(rst), .bus(if_w));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish before 200000");
    $fatal(1, "watchdog");
  end

  // Reference model: index 0 saturating, index 1 wrapping
  int m_cnt[2];
  int m_rel[2];
  int m_tc[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0;
      m_rel[k] = 0;
      m_tc[k]  = 0;
    end
  endtask

  task automatic model_step(input bit l, input bit d, input bit i, input int v);
    int nxt;
    int t;
    bit sat;
    for (int k = 0; k < 2; k++) begin
      sat = (k == 0);
      nxt = m_cnt[k];
      t   = 0;
      if (l) begin
        nxt      = v;
        m_rel[k] = v;
      end else if (i && !d) begin
        nxt = m_cnt[k] + 1;
        if (nxt > MAXV) begin
          nxt = sat ? MAXV : nxt % (MAXV + 1);
          t   = sat ? 0 : 1;
        end
      end else if (d && !i) begin
        nxt = m_cnt[k] - 1;
        if (nxt == 0) begin
          t = 1;
        end else if (nxt < 0) begin
`ifdef CNT_RELOAD_EN
          nxt = m_rel[k];
          t   = 1;
`else
          nxt = sat ? 0 : nxt + (MAXV + 1);
`endif
        end
      end
      m_cnt[k] = nxt;
      m_tc[k]  = t;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (txn %0d)", nm, act, req, txn);
    end
  endtask

  task automatic chk_dut(input string tag, input int k, input int ec, input int et);
    logic [W-1:0] c;
    logic t, z, f;
    if (k == 0) begin
      c = if_s.count; t = if_s.tc; z = if_s.zero; f = if_s.full;
    end else begin
      c = if_w.count; t = if_w.tc; z = if_w.zero; f = if_w.full;
    end
    chk({tag, "_count"}, 32'(c), 32'(ec));
    chk({tag, "_tc"},    32'(t), 32'(et));
    chk({tag, "_zero"},  32'(z), 32'(ec == 0));
    chk({tag, "_full"},  32'(f), 32'(ec == MAXV));
  endtask

  task automatic drive(input bit l, input bit d, input bit i, input logic [W-1:0] v);
    if_s.latch = l; if_s.dec = d; if_s.inc = i; if_s.in = v;
    if_w.latch = l; if_w.dec = d; if_w.inc = i; if_w.in = v;
  endtask

  // One clocked transaction; returns 1 ns after the edge with the model updated
  task automatic apply(input bit l, input bit d, input bit i, input logic [W-1:0] v);
    drive(l, d, i, v);
    model_step(l, d, i, int'(v));
    @(posedge clk);
    #1;
    txn++;
    $display("txn %0d l=%0b d=%0b i=%0b in=%h | sat cnt=%h tc=%b | wrap cnt=%h tc=%b",
             txn, l, d, i, v, if_s.count, if_s.tc, if_w.count, if_w.tc);
  endtask

  typedef struct {
    bit l;
    bit d;
    bit i;
    logic [W-1:0] v;
    int es;
    int ts;
    int ew;
    int tw;
  } vec_t;

  vec_t tbl[15];

  initial begin
    // Vectors applied back to back starting from reset (count 0, reload 0)
    tbl[0]  = '{1, 0, 0, 4'h3, 3,  0, 3,  0};
    tbl[1]  = '{0, 1, 0, 4'h0, 2,  0, 2,  0};
    tbl[2]  = '{0, 1, 0, 4'h0, 1,  0, 1,  0};
    tbl[3]  = '{0, 1, 0, 4'h0, 0,  1, 0,  1};
    tbl[4]  = '{1, 1, 0, 4'h9, 9,  0, 9,  0};
    tbl[5]  = '{1, 1, 0, 4'h5, 5,  0, 5,  0};
    tbl[6]  = '{0, 1, 1, 4'h0, 5,  0, 5,  0};
    tbl[7]  = '{1, 0, 0, 4'hF, 15, 0, 15, 0};
    tbl[8]  = '{0, 0, 1, 4'h0, 15, 0, 0,  1};
    tbl[9]  = '{0, 0, 1, 4'h0, 15, 0, 1,  0};
    tbl[10] = '{0, 1, 0, 4'h0, 14, 0, 0,  1};
    tbl[11] = '{1, 0, 0, 4'h0, 0,  0, 0,  0};
`ifdef CNT_RELOAD_EN
    tbl[12] = '{0, 1, 0, 4'h0, 0,  1, 0,  1};
`else
    tbl[12] = '{0, 1, 0, 4'h0, 0,  0, 15, 0};
`endif
    tbl[13] = '{1, 1, 1, 4'h8, 8,  0, 8,  0};
    tbl[14] = '{0, 0, 1, 4'h0, 9,  0, 9,  0};

    // Reset with a load pending: outputs must stay cleared
    rst = 1'b1;
    drive(1, 0, 0, 4'hA);
    #1;
    chk_dut("rst_async_s", 0, 0, 0);
    chk_dut("rst_async_w", 1, 0, 0);
    for (int n = 0; n < 3; n++) begin
      @(posedge clk);
      #1;
      chk_dut("rst_hold_s", 0, 0, 0);
      chk_dut("rst_hold_w", 1, 0, 0);
    end
    rst = 1'b0;
    model_reset();

    // Table vectors
    for (int n = 0; n < 15; n++) begin
      apply(tbl[n].l, tbl[n].d, tbl[n].i, tbl[n].v);
      chk_dut("tbl_s", 0, tbl[n].es, tbl[n].ts);
      chk_dut("tbl_w", 1, tbl[n].ew, tbl[n].tw);
    end

    // Reload sequence: latch 2 then four decrements
    apply(1, 0, 0, 4'h2);
    chk_dut("rl_ld_s", 0, 2, 0);
    apply(0, 1, 0, 4'h0);
    chk_dut("rl_d1_s", 0, 1, 0);
    apply(0, 1, 0, 4'h0);
    chk_dut("rl_d2_s", 0, 0, 1);
    chk_dut("rl_d2_w", 1, 0, 1);
    apply(0, 1, 0, 4'h0);
`ifdef CNT_RELOAD_EN
    chk_dut("rl_d3_s", 0, 2, 1);
    chk_dut("rl_d3_w", 1, 2, 1);
`else
    chk_dut("rl_d3_s", 0, 0, 0);
    chk_dut("rl_d3_w", 1, 15, 0);
`endif
    apply(0, 1, 0, 4'h0);
`ifdef CNT_RELOAD_EN
    chk_dut("rl_d4_s", 0, 1, 0);
    chk_dut("rl_d4_w", 1, 1, 0);
`else
    chk_dut("rl_d4_s", 0, 0, 0);
    chk_dut("rl_d4_w", 1, 14, 0);
`endif

    // Asynchronous reset between edges while a decrement is pending
    apply(1, 0, 0, 4'h7);
    chk_dut("mr_ld_s", 0, 7, 0);
    drive(0, 1, 0, 4'h0);
    #2;
    rst = 1'b1;
    #1;
    chk_dut("mr_async_s", 0, 0, 0);
    chk_dut("mr_async_w", 1, 0, 0);
    #2;
    rst = 1'b0;
    model_reset();
    apply(0, 1, 0, 4'h0);
`ifdef CNT_RELOAD_EN
    chk_dut("mr_post_s", 0, 0, 1);
    chk_dut("mr_post_w", 1, 0, 1);
`else
    chk_dut("mr_post_s", 0, 0, 0);
    chk_dut("mr_post_w", 1, 15, 0);
`endif

    // Random stimulus against the reference model
    for (int n = 0; n < 400; n++) begin
      bit l, d, i;
      logic [W-1:0] v;
      l = ($urandom_range(0, 7) == 0);
      d = $urandom_range(0, 1) == 1;
      i = $urandom_range(0, 1) == 1;
      v = W'($urandom_range(0, MAXV));
      apply(l, d, i, v);
      chk_dut("rnd_s", 0, m_cnt[0], m_tc[0]);
      chk_dut("rnd_w", 1, m_cnt[1], m_tc[1]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cnt_updn_ld.md
CNT_UPDN_LD -- requirements
Module: cnt_updn_ld

Interface
REQ-001 Parameter WIDTH, default 4: counter and load-value width, legal range 2..32.
REQ-002 Parameter SATURATE, default 1: 1 = clamp at 0 and at max; 0 = wrap modulo 2^WIDTH.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in  input  WIDTH  load value.
REQ-006 latch  input  1  load request: count takes in.
REQ-007 dec  input  1  decrement request.
REQ-008 inc  input  1  increment request.
REQ-009 count  output  WIDTH  current count, registered.
REQ-010 zero  output  1  high iff count == 0, decoded from register.
REQ-011 full  output  1  high iff count == 2^WIDTH-1, decoded from register.
REQ-012 tc  output  1  terminal-count pulse, registered, one cycle wide.

Function
REQ-013 Priority per cycle SHALL be latch > (inc XOR dec) > hold.
REQ-014 latch=1: count <= in next edge; inc/dec ignored; tc <= 0.
REQ-015 latch=0, inc=1, dec=1: count unchanged, tc <= 0.
REQ-016 latch=0, dec=1, inc=0, count>0: count <= count-1.
REQ-017 latch=0, inc=1, dec=0, count<max: count <= count+1.
REQ-018 dec at count==0: SATURATE=1 holds 0; SATURATE=0 wraps to max; CNT_RELOAD_EN behaviour per REQ-028 overrides both.
REQ-019 inc at count==max: SATURATE=1 holds max; SATURATE=0 wraps to 0.
REQ-020 tc <= 1 for exactly one cycle after any edge where a dec moves count from 1 to 0, or an inc wraps max to 0; otherwise tc <= 0.
REQ-021 Latch-to-count latency 1 cycle; inc/dec-to-count latency 1 cycle; zero/full follow count with no extra cycle.
REQ-022 Input arithmetic SHALL be exactly WIDTH bits; no carry/borrow visible except via tc.

Reset
REQ-023 rst=1 SHALL immediately force count=0, tc=0, and reload register=0, independent of clk.
REQ-024 During reset zero=1, full=0.
REQ-025 rst asserted mid-count SHALL discard any pending latch/inc/dec; first update after deassertion occurs on the next rising clk edge.
REQ-026 No X on any output after reset, for any input values.

Configuration
REQ-027 Macro CNT_RELOAD_EN compiles in an auto-reload register reload_q (WIDTH bits), written with in on every latch.
REQ-028 With CNT_RELOAD_EN: dec at count==0 (latch=0, inc=0) SHALL load count <= reload_q and pulse tc <= 1; count==1 -> 0 still pulses tc.
REQ-029 Without CNT_RELOAD_EN: no reload register exists; REQ-018 SATURATE behaviour applies unchanged.

Verification
REQ-030 Reset: rst=1 with latch=1, in=4'hA -> count=0, zero=1, tc=0 throughout reset.
REQ-031 Load/countdown, WIDTH=4: latch in=4'h3, then dec x3 -> count 3,2,1,0; tc=1 only in the cycle after 1->0; zero=1 after third dec.
REQ-032 Priority: latch=1, dec=1, in=4'h5 at count=9 -> count=5; then inc=1, dec=1 -> count stays 5.
REQ-033 Saturate vs wrap: count=0, dec -> SATURATE=1 gives 0 with tc=0; SATURATE=0 gives 4'hF. count=4'hF, inc -> SATURATE=1 gives 4'hF with full=1; SATURATE=0 gives 0 with tc=1.
REQ-034 Reload (CNT_RELOAD_EN): latch in=4'h2, dec x3 -> count 1, 0 with tc, then 2 with tc; without macro the third dec holds 0 (SATURATE=1).
REQ-035 Mid-operation reset: count=7, dec active, rst pulsed asynchronously between edges -> count=0 immediately; next edge with dec=1 and SATURATE=1 keeps 0.
